// File: rtl/ddc_cic_capture.sv
// ddc_cic_capture: LO mixer, N-stage CIC decimator and circular {I,Q} capture buffer with host read port
module ddc_cic_capture #(
    parameter int  DIN_W    = 16,
    parameter int  LO_W     = 16,
    parameter int  OUT_W    = 16,
    parameter int  CIC_N    = 3,
    parameter int  CIC_RMAX = 64,
    parameter int  DEPTH    = 11520,
    localparam int ACC_W    = DIN_W + CIC_N * $clog2(CIC_RMAX),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [DIN_W-1:0]   s_tdata,
    input  logic [LO_W-1:0]    lo_cos,
    input  logic [LO_W-1:0]    lo_sin,
    input  logic [7:0]         cfg_dec,
    input  logic [5:0]         cfg_shift,
    input  logic               cfg_mode,
    input  logic               cfg_arm,
    input  logic               cfg_stop,
    input  logic [AW-1:0]      rd_addr,
    output logic [2*OUT_W-1:0] rd_data,
    output logic [AW-1:0]      wr_addr_pub,
    output logic [15:0]        wrap_cnt,
    output logic               cap_busy,
    output logic               cap_done
);
    localparam int PW = DIN_W + LO_W;
    localparam logic [7:0] RMAX = 8'(CIC_RMAX);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              r_q, r_d, cnt_q, cnt_d;
    logic [5:0]              shift_q, shift_d;
    logic                    mode_q, mode_d, v1_q, v1_d, v2_q, v2_d, ev_q, ev_d, we, run;
    logic signed [PW-1:0]    p_q [2], p_d [2];
    logic signed [DIN_W-1:0] x_q [2], x_d [2];
    logic signed [ACC_W-1:0] integ_q [2][CIC_N], integ_d [2][CIC_N];
    logic signed [ACC_W-1:0] dly_q [2][CIC_N], dly_d [2][CIC_N];
    logic [AW-1:0]           wptr_q, wptr_d, pub_q, pub_d;
    logic [15:0]             wrap_q, wrap_d;
    logic [2*OUT_W-1:0]      wdata, rd_q;
    logic [2*OUT_W-1:0]      mem [DEPTH];

    function automatic logic signed [DIN_W-1:0] mix_sat(input logic signed [PW-1:0] p);
        logic [PW-1:0] s;
        s = p << 1;
        return p[PW-1:PW-2] == 2'b01 ? {1'b0, {(DIN_W-1){1'b1}}} :
               p[PW-1:PW-2] == 2'b10 ? {1'b1, {(DIN_W-1){1'b0}}} : s[PW-1 -: DIN_W];
    endfunction

    function automatic logic [OUT_W-1:0] out_sat(input logic signed [ACC_W-1:0] y);
        return y > OMAX ? OMAX[OUT_W-1:0] : y < OMIN ? OMIN[OUT_W-1:0] : y[OUT_W-1:0];
    endfunction

    assign run = state_q == RUN;

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic [OUT_W-1:0] y [2];
        state_d = state_q;
        r_d = r_q;
        shift_d = shift_q;
        mode_d = mode_q;
        cnt_d = cnt_q;
        wptr_d = wptr_q;
        pub_d = pub_q;
        wrap_d = wrap_q;
        integ_d = integ_q;
        dly_d = dly_q;
        we = 1'b0;
        ev_d = 1'b0;
        v1_d = s_tvalid & run;
        v2_d = v1_q & run;
        p_d[0] = $signed(s_tdata) * $signed(lo_cos);
        p_d[1] = $signed(s_tdata) * $signed(lo_sin);
        for (int c = 0; c < 2; c++) begin
            x_d[c] = mix_sat(p_q[c]);
            acc = ACC_W'(x_q[c]);
            for (int k = 0; k < CIC_N; k++) begin
                acc = integ_q[c][k] + acc;
                if (v2_q & run) integ_d[c][k] = acc;
            end
            // comb chain runs at the decimated rate, so each delay holds the previous event's value
            acc = integ_q[c][CIC_N-1];
            for (int k = 0; k < CIC_N; k++) begin
                if (ev_q & run) dly_d[c][k] = acc;
                acc = acc - dly_q[c][k];
            end
            y[c] = out_sat(acc >>> shift_q);
        end
        wdata = {y[0], y[1]};
        if (v2_q & run) begin
            ev_d = cnt_q == r_q - 8'd1;
            cnt_d = ev_d ? 8'd0 : cnt_q + 8'd1;
        end
        if (ev_q & run) begin
            we = 1'b1;
            pub_d = wptr_q;
            wptr_d = wptr_q == LAST ? '0 : wptr_q + AW'(1);
            if (wptr_q == LAST && mode_q) state_d = DONE;
            if (wptr_q == LAST && !mode_q && wrap_q != 16'hFFFF) wrap_d = wrap_q + 16'd1;
        end
        if (cfg_stop && state_q != IDLE) state_d = IDLE;
        if (cfg_arm) begin
            state_d = RUN;
            r_d = cfg_dec == 8'd0 ? 8'd1 : cfg_dec > RMAX ? RMAX : cfg_dec;
            shift_d = cfg_shift;
            mode_d = cfg_mode;
            cnt_d = '0;
            wptr_d = '0;
            pub_d = '0;
            wrap_d = '0;
            we = 1'b0;
            v1_d = 1'b0;
            v2_d = 1'b0;
            ev_d = 1'b0;
            integ_d = '{default: '0};
            dly_d = '{default: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q <= 8'd1;
            shift_q <= '0;
            mode_q <= 1'b0;
            cnt_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            ev_q <= 1'b0;
            p_q <= '{default: '0};
            x_q <= '{default: '0};
            integ_q <= '{default: '0};
            dly_q <= '{default: '0};
            wptr_q <= '0;
            pub_q <= '0;
            wrap_q <= '0;
        end else begin
            state_q <= state_d;
            r_q <= r_d;
            shift_q <= shift_d;
            mode_q <= mode_d;
            cnt_q <= cnt_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            ev_q <= ev_d;
            p_q <= p_d;
            x_q <= x_d;
            integ_q <= integ_d;
            dly_q <= dly_d;
            wptr_q <= wptr_d;
            pub_q <= pub_d;
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge clk) if (we) mem[wptr_q] <= wdata;

    // read-before-write: a same-address read in the write cycle returns the old entry
    always_ff @(posedge clk) rd_q <= rst ? '0 : mem[rd_addr];

    assign s_tready = run;
    assign cap_busy = run;
    assign cap_done = state_q == DONE;
    assign rd_data = rd_q;
    assign wr_addr_pub = pub_q;
    assign wrap_cnt = wrap_q;
endmodule
